// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   dmem_mode_e  : access size encoding carried on req_mode
//   dmem_state_e : responder FSM states
//   STRB_W       : number of byte lanes in a 32-bit word
package dmem_pkg;

  typedef enum logic [1:0] {
    DMEM_MODE_WORD = 2'b00,
    DMEM_MODE_HALF = 2'b01,
    DMEM_MODE_BYTE = 2'b10,
    DMEM_MODE_RSVD = 2'b11
  } dmem_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  localparam int STRB_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Optional macro: DMEM_ALIGN_CHECK_EN (misaligned half/word accesses are
// rejected instead of being forced to natural alignment).
//   mode     in  2   access size (dmem_mode_e encoding)
//   offset   in  2   byte offset within the word (addr[1:0])
//   wdata    in  32  store data, right-justified
//   rword    in  32  raw word read from storage
//   strb     out 4   byte-lane write strobes (all zero when err)
//   wplaced  out 32  store data replicated into every lane
//   rdata    out 32  load data, right-justified, zero-filled (0 when err)
//   misalign out 1   offset is not naturally aligned for the size
//   err      out 1   access must be rejected
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [1:0]        offset,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rword,
  output logic [STRB_W-1:0] strb,
  output logic [31:0]       wplaced,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              err
);

  logic rsvd;
  logic half_hi;

  always_comb begin
    strb     = '0;
    wplaced  = '0;
    rdata    = '0;
    misalign = 1'b0;
    rsvd     = 1'b0;
    // Half accesses pick the upper half on offset[1]; offset[0] is dropped,
    // which is exactly the forced-alignment behaviour.
    half_hi  = offset[1];
    case (mode)
      DMEM_MODE_WORD: begin
        misalign = (offset != 2'b00);
        strb     = 4'b1111;
        wplaced  = wdata;
        rdata    = rword;
      end
      DMEM_MODE_HALF: begin
        misalign = offset[0];
        strb     = half_hi ? 4'b1100 : 4'b0011;
        wplaced  = {2{wdata[15:0]}};
        rdata    = {16'h0000, (half_hi ? rword[31:16] : rword[15:0])};
      end
      DMEM_MODE_BYTE: begin
        strb     = 4'b0001 << offset;
        wplaced  = {4{wdata[7:0]}};
        rdata    = {24'h000000, rword[{offset, 3'b000} +: 8]};
      end
      default: begin
        rsvd = 1'b1;
      end
    endcase

`ifdef DMEM_ALIGN_CHECK_EN
    err = rsvd | misalign;
`else
    err = rsvd;
`endif

    if (err) begin
      strb  = '0;
      rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port. One request at a
// time, LATENCY wait states, byte-lane stores, right-justified zero-filled
// loads. Optional macro: DMEM_ALIGN_CHECK_EN (see dmem_lane_align).
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       idle, can accept
//   req_write  in   1       1 = store, 0 = load
//   req_mode   in   2       00 word, 01 half, 10 byte, 11 reserved
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   32      store data, right-justified
//   resp_valid out  1       response present
//   resp_ready in   1       requester consumes response
//   resp_rdata out  32      load data (0 for stores / errors)
//   resp_err   out  1       request rejected, nothing written
//   busy       out  1       not idle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int         DEPTH   = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  dmem_state_e state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic              write_reg;
  logic [1:0]        mode_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  logic              accept;
  logic              commit;
  logic              mem_we;
  logic              cur_write;
  logic [1:0]        cur_mode;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [ADDR_W-3:0] word_idx;

  logic [STRB_W-1:0] al_strb;
  logic [31:0]       al_wplaced;
  logic [31:0]       al_rdata;
  logic [31:0]       rword;
  logic              al_misalign;
  logic              al_err;

  assign accept     = req_valid && (state_reg == ST_IDLE);
  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign busy       = (state_reg != ST_IDLE);

  // With LATENCY=0 the commit happens on the accept edge, before the request
  // registers are loaded, so the live inputs are used while idle.
  assign cur_write = (state_reg == ST_IDLE) ? req_write : write_reg;
  assign cur_mode  = (state_reg == ST_IDLE) ? req_mode  : mode_reg;
  assign cur_addr  = (state_reg == ST_IDLE) ? req_addr  : addr_reg;
  assign cur_wdata = (state_reg == ST_IDLE) ? req_wdata : wdata_reg;
  assign word_idx  = cur_addr[ADDR_W-1:2];

  // Store commit and load capture happen on the edge that enters RESP.
  assign commit = (state_next == ST_RESP) && (state_reg != ST_RESP);
  assign mem_we = commit && cur_write && rst_n;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          cnt_next   = LAT_CNT;
          state_next = (LAT_CNT == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      write_reg  <= 1'b0;
      mode_reg   <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg <= req_write;
        mode_reg  <= req_mode;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (commit) begin
        resp_rdata <= cur_write ? 32'h0 : al_rdata;
        resp_err   <= al_err;
      end
    end
  end

  dmem_lane_align u_align (
    .mode     (cur_mode),
    .offset   (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .rword    (rword),
    .strb     (al_strb),
    .wplaced  (al_wplaced),
    .rdata    (al_rdata),
    .misalign (al_misalign),
    .err      (al_err)
  );

  // One byte-wide array per lane gives clean per-byte write enables.
  // Storage is deliberately left out of reset.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (mem_we && al_strb[gi]) lane_mem[word_idx] <= al_wplaced[gi*8 +: 8];
      end
      assign rword[gi*8 +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // The misalign flag only matters when alignment checking is enabled.
  logic unused_misalign;
  assign unused_misalign = al_misalign;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int ADDR_W = 12;
  localparam int LAT    = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_mode = 2'b00;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  mode;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue one request from a posedge+1 time point; returns the number of
  // clock edges from the accept edge until resp_valid is seen.
  task automatic do_req(input logic wr, input logic [1:0] mode, input logic [11:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd,
                        output logic err, output int lat);
    req_valid = 1'b1;
    req_write = wr;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = resp_rdata;
    err = resp_err;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " resp_valid drop"}, 32'(resp_valid), 32'd0);
    chk({tag, " req_ready back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 2'b00, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'b00, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 12'h010, 32'h11223344, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 2'b10, 12'h013, 32'h555555AB, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 12'h010, 32'h0, 32'hAB223344, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 12'h013, 32'h0, 32'h000000AB, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 12'h011, 32'h0, 32'h00000033, 1'b0};
    vecs[7]  = '{1'b1, 2'b00, 12'h020, 32'h01020304, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 12'h022, 32'h1234CAFE, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 12'h022, 32'h0, 32'h0000CAFE, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 12'h020, 32'h0, 32'hCAFE0304, 1'b0};
    vecs[11] = '{1'b0, 2'b01, 12'h020, 32'h0, 32'h00000304, 1'b0};
    vecs[12] = '{1'b1, 2'b11, 12'h020, 32'hFFFFFFFF, 32'h0, 1'b1};
    vecs[13] = '{1'b0, 2'b11, 12'h020, 32'h0, 32'h0, 1'b1};
    vecs[14] = '{1'b0, 2'b00, 12'h020, 32'h0, 32'hCAFE0304, 1'b0};
    vecs[15] = '{1'b1, 2'b00, 12'h030, 32'hA5A5A5A5, 32'h0, 1'b0};
    vecs[16] = '{1'b0, 2'b00, 12'h031, 32'h0, ALIGN_EN ? 32'h0 : 32'hA5A5A5A5, ALIGN_EN};
    vecs[17] = '{1'b1, 2'b00, 12'h031, 32'h5A5A5A5A, 32'h0, ALIGN_EN};
    vecs[18] = '{1'b0, 2'b00, 12'h030, 32'h0, ALIGN_EN ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 1'b0};
    vecs[19] = '{1'b0, 2'b01, 12'h033, 32'h0, ALIGN_EN ? 32'h0 : 32'h00005A5A, ALIGN_EN};
    vecs[20] = '{1'b1, 2'b10, 12'h032, 32'hEEEEEE77, 32'h0, 1'b0};
    vecs[21] = '{1'b0, 2'b00, 12'h030, 32'h0, ALIGN_EN ? 32'hA577A5A5 : 32'h5A775A5A, 1'b0};

    // Reset state
    #12;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rdata", resp_rdata, 32'h0);
    chk("reset err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
      do_req(vecs[i].wr, vecs[i].mode, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      $display("vec %0d wr=%0b mode=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
               i, vecs[i].wr, vecs[i].mode, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({tag, " latency"}, 32'(lat), 32'(LAT + 1));
      chk({tag, " rdata"}, rd, vecs[i].exp_rdata);
      chk({tag, " err"}, 32'(er), 32'(vecs[i].exp_err));
      chk({tag, " req_ready in RESP"}, 32'(req_ready), 32'd0);
      finish_resp(tag);
    end

    // Back-pressure: response must hold while resp_ready stays low
    do_req(1'b0, 2'b00, 12'h010, 32'h0, rd, er, lat);
    $display("hold load addr=010 -> rdata=%h err=%0b lat=%0d", rd, er, lat);
    chk("hold first rdata", rd, 32'hAB223344);
    held = rd;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 12'h010;
    req_wdata = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d resp_valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("hold%0d rdata", c), resp_rdata, held);
      chk($sformatf("hold%0d req_ready", c), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    finish_resp("hold");
    chk("hold busy after", 32'(busy), 32'd0);

    // Reset during WAIT of a store: store dropped, outputs return to reset values
    req_valid = 1'b1;
    req_write = 1'b1;
    req_mode  = 2'b00;
    req_addr  = 12'h010;
    req_wdata = 32'h99999999;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort busy in WAIT", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("abort store addr=010 wdata=99999999 reset asserted mid-wait");
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort resp_valid", 32'(resp_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rdata", resp_rdata, 32'h0);
    chk("abort err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 2'b00, 12'h010, 32'h0, rd, er, lat);
    $display("post-abort load addr=010 -> rdata=%h err=%0b lat=%0d", rd, er, lat);
    chk("abort word kept", rd, 32'hAB223344);
    chk("abort latency", 32'(lat), 32'(LAT + 1));
    finish_resp("post-abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
